// File: rtl/stopwatch_display.sv
// MM.SS driver for a common-anode, 4-digit multiplexed 7-segment display.
// Optional paused-state blinking is built when STOPWATCH_DISPLAY_PAUSE_BLINK_EN is defined.
module stopwatch_display #(
  parameter int SCAN_DIV     = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n
);

  localparam int              SCW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_BLANK = 7'h7F;
  localparam logic [6:0]      SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_PAUSE    = 2'b10,
    ST_IDLE_ALT = 2'b11
  } status_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_encode = 7'h40;
      4'd1:    seg_encode = 7'h79;
      4'd2:    seg_encode = 7'h24;
      4'd3:    seg_encode = 7'h30;
      4'd4:    seg_encode = 7'h19;
      4'd5:    seg_encode = 7'h12;
      4'd6:    seg_encode = 7'h02;
      4'd7:    seg_encode = 7'h78;
      4'd8:    seg_encode = 7'h00;
      4'd9:    seg_encode = 7'h10;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]     digit_q, digit_d;
  logic [7:0]     snap_min_q, snap_min_d;
  logic [5:0]     snap_sec_q, snap_sec_d;
  status_e        snap_st_q, snap_st_d;
  logic           frame_start;
  logic           blank_frame;
  logic           pause_dp_n;
  logic [6:0]     seg_d;
  logic           dp_d;
  logic [3:0]     an_d;

  // The snapshot is taken on the same edge that first shows digit 3, so the
  // displayed digits are decoded from the next-state snapshot, not the register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    frame_start = (digit_q == 2'd3) && (scan_cnt_q == '0);
    snap_min_d  = snap_min_q;
    snap_sec_d  = snap_sec_q;
    snap_st_d   = snap_st_q;
    if (frame_start) begin
      snap_min_d = minutes;
      snap_sec_d = seconds;
      snap_st_d  = status_e'(status);
    end

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      digit_d    = digit_q - 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      digit_d    = digit_q;
    end
  end

`ifdef STOPWATCH_DISPLAY_PAUSE_BLINK_EN
  localparam int BCW = $clog2(BLINK_FRAMES + 1);

  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;

  // blink_cnt counts paused frames already shown in the current phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_start) begin
      if (snap_st_d != ST_PAUSE) begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BCW'(BLINK_FRAMES)) begin
        blink_cnt_d = BCW'(1);
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blank_frame = (snap_st_d == ST_PAUSE) && !blink_on_d;
  assign pause_dp_n  = ~blink_on_d;
`else
  // No blinking in this build; the compare folds to 0 for any legal BLINK_FRAMES.
  assign blank_frame = (BLINK_FRAMES < 1);
  assign pause_dp_n  = 1'b1;
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    unique case (digit_q)
      2'd3: seg_d = (snap_min_d > 8'd99) ? SEG_DASH : seg_encode(4'(snap_min_d / 8'd10));
      2'd2: seg_d = (snap_min_d > 8'd99) ? SEG_DASH : seg_encode(4'(snap_min_d % 8'd10));
      2'd1: seg_d = seg_encode(4'(snap_sec_d / 6'd10));
      2'd0: seg_d = seg_encode(4'(snap_sec_d % 6'd10));
    endcase

    if (digit_q == 2'd2) begin
      unique case (snap_st_d)
        ST_RUN:   dp_d = 1'b0;
        ST_PAUSE: dp_d = pause_dp_n;
        default:  dp_d = 1'b1;
      endcase
    end

    if (blank_frame) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end

    an_d = ~(4'b0001 << digit_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      scan_cnt_q <= '0;
      digit_q    <= 2'd3;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      snap_st_q  <= ST_IDLE;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= 4'hF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      snap_min_q <= snap_min_d;
      snap_sec_q <= snap_sec_d;
      snap_st_q  <= snap_st_d;
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: a cycle-position model pushes the expected
// display word before each edge, and each test pops and compares it after the edge.
`timescale 1ns/1ps
module tb_stopwatch_display;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [1:0] status = '0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  disp_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: position within the frame counted from release of reset.
  int         pos = 0;
  int         paused_frames = 0;
  bit         phase_on = 1'b1;
  logic [7:0] m_snap = '0;
  logic [5:0] s_snap = '0;
  logic [1:0] st_snap = '0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  stopwatch_display #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n)
  );

  function automatic string fmt(input disp_t d);
    return $sformatf("an_n=%h seg_n=%h dp_n=%b", d.an, d.seg, d.dp);
  endfunction

  // Predict what the coming edge should produce, then advance one edge.
  task automatic drive_edge();
    disp_t e;
    int    dig;
    if (!rst_n) begin
      e             = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
      pos           = 0;
      m_snap        = '0;
      s_snap        = '0;
      st_snap       = '0;
      paused_frames = 0;
      phase_on      = 1'b1;
    end else begin
      if (pos == 0) begin
        m_snap  = minutes;
        s_snap  = seconds;
        st_snap = status;
        if (st_snap == 2'b10) begin
          phase_on = ((paused_frames / BLINK_FRAMES) % 2) == 0;
          paused_frames++;
        end else begin
          paused_frames = 0;
          phase_on      = 1'b1;
        end
      end
      dig      = 3 - pos / SCAN_DIV;
      e.an     = 4'hF;
      e.an[dig] = 1'b0;
      e.dp     = 1'b1;
      case (dig)
        3:       e.seg = (m_snap > 99) ? 7'h3F : seg_tab[m_snap / 10];
        2:       e.seg = (m_snap > 99) ? 7'h3F : seg_tab[m_snap % 10];
        1:       e.seg = seg_tab[s_snap / 10];
        default: e.seg = seg_tab[s_snap % 10];
      endcase
      if (dig == 2 && st_snap == 2'b01) e.dp = 1'b0;
`ifdef STOPWATCH_DISPLAY_PAUSE_BLINK_EN
      if (st_snap == 2'b10) begin
        if (phase_on) begin
          if (dig == 2) e.dp = 1'b0;
        end else begin
          e.seg = 7'h7F;
          e.dp  = 1'b1;
        end
      end
`endif
      pos = (pos + 1) % FRAME;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    disp_t got, exp;
    rst_n   = 1'b0;
    minutes = 8'd12;
    seconds = 6'd34;
    status  = 2'b01;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst_n = 1'b1;
      drive_edge();
      got = '{an: an_n, seg: seg_n, dp: dp_n};
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_running();
    disp_t got, exp;
    for (int i = 0; i < 2 * FRAME - 1; i++) begin
      drive_edge();
      got = '{an: an_n, seg: seg_n, dp: dp_n};
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL running[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_mid_frame_change();
    disp_t got, exp;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 6) seconds = 6'd35;
      drive_edge();
      got = '{an: an_n, seg: seg_n, dp: dp_n};
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL snapshot_hold[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_boundaries();
    disp_t got, exp;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == 0)         begin minutes = 8'd150; seconds = 6'd59; status = 2'b01; end
      if (i == FRAME)     begin minutes = 8'd99;  seconds = 6'd63; status = 2'b11; end
      if (i == 2 * FRAME) begin minutes = 8'd100; seconds = 6'd60; status = 2'b00; end
      drive_edge();
      got = '{an: an_n, seg: seg_n, dp: dp_n};
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL boundary[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_pause_blink();
    disp_t got, exp;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (i == 0)         begin minutes = 8'd5; seconds = 6'd7; status = 2'b10; end
      if (i == 5 * FRAME) status = 2'b01;
      if (i == 6 * FRAME) status = 2'b10;
      drive_edge();
      got = '{an: an_n, seg: seg_n, dp: dp_n};
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL pause_blink[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    disp_t got, exp;
    minutes = 8'd27;
    seconds = 6'd48;
    status  = 2'b01;
    for (int i = 0; i < 10 + 1 + FRAME; i++) begin
      if (i == 10) begin
        rst_n   = 1'b0;
        minutes = 8'd42;
        seconds = 6'd17;
      end
      if (i == 11) rst_n = 1'b1;
      drive_edge();
      got = '{an: an_n, seg: seg_n, dp: dp_n};
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset_mid[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  initial begin
    test_reset();
    test_running();
    test_mid_frame_change();
    test_boundaries();
    test_pause_blink();
    test_reset_mid_frame();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
